// File: rtl/dmem_resp.sv
// Data-memory responder: word RAM, free-running timer with compare match, and
// a transmit byte queue with status/overflow flags, all on one address bus.
// Optional feature: the timer is built only when DMEM_TIMER_EN is defined;
// otherwise its registers read as zero and timer_irq is tied low.
module dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned TXQ_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(TXQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] OffCount  = 2'd0;
  localparam logic [1:0] OffCmp    = 2'd1;
  localparam logic [1:0] OffTx     = 2'd2;
  localparam logic [1:0] OffStatus = 2'd3;

  // Address decode; byte offset and RAM alias bits are don't-care.
  logic          ram_sel, io_sel;
  logic [1:0]    io_off;
  logic [AW-1:0] ram_idx;
  logic          unused_addr;

  assign ram_sel     = (addr[31:16] == 16'h0000);
  assign io_sel      = (addr[31:4] == 28'hFFFF000);
  assign io_off      = addr[3:2];
  assign ram_idx     = addr[AW+1:2];
  assign unused_addr = ^{addr[15:AW+2], addr[1:0]};

  logic ram_we, count_wr, cmp_wr, status_wr, push_req;

  assign ram_we    = mem_write && ram_sel && !rst;
  assign count_wr  = mem_write && io_sel && (io_off == OffCount);
  assign cmp_wr    = mem_write && io_sel && (io_off == OffCmp);
  assign push_req  = mem_write && io_sel && (io_off == OffTx);
  assign status_wr = mem_write && io_sel && (io_off == OffStatus);

  // RAM storage; intentionally not reset.
  logic [31:0] ram_q [DEPTH_WORDS];

  // RAM write port; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= wdata;
    end
  end

  // Transmit queue
  logic [7:0]    txq_q [TXQ_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          q_full, q_empty, pop, push;

  assign q_full   = (count_q == CW'(TXQ_DEPTH));
  assign q_empty  = (count_q == '0);
  assign pop      = !q_empty && tx_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push     = push_req && (!q_full || pop);
  assign tx_valid = !q_empty;
  assign tx_data  = q_empty ? 8'h00 : txq_q[rd_ptr_q];

  // Queue pointer and occupancy next-state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue data storage; contents past the pointers are don't-care.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      txq_q[wr_ptr_q] <= wdata[7:0];
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (status_wr && wdata[3]) ovf_d = 1'b0;
    if (push_req && !push)     ovf_d = 1'b1;
  end

  logic [31:0] count_rd, cmp_rd;
  logic        match_rd;

`ifdef DMEM_TIMER_EN
  logic [31:0] tcount_q, tcount_d, tcmp_q, tcmp_d;
  logic        match_q, match_d;

  // Timer next-state: a CPU load replaces that cycle's increment.
  always_comb begin
    tcount_d = count_wr ? wdata : tcount_q + 32'd1;
    tcmp_d   = cmp_wr ? wdata : tcmp_q;
    match_d  = match_q;
    if (status_wr && wdata[2]) match_d = 1'b0;
    if (tcount_q == tcmp_q)    match_d = 1'b1;
  end

  // Timer state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcount_q <= '0;
      tcmp_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      match_q  <= match_d;
    end
  end

  assign count_rd = tcount_q;
  assign cmp_rd   = tcmp_q;
  assign match_rd = match_q;
`else
  assign count_rd = '0;
  assign cmp_rd   = '0;
  assign match_rd = 1'b0;
`endif

  assign timer_irq = match_rd;

  // Queue and status state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Zero-latency read mux; unmapped and write-only locations read as zero.
  always_comb begin
    rdata = 32'h0;
    if (ram_sel) begin
      rdata = ram_q[ram_idx];
    end else if (io_sel) begin
      case (io_off)
        OffCount:  rdata = count_rd;
        OffCmp:    rdata = cmp_rd;
        OffStatus: rdata = {28'h0, ovf_q, match_rd, q_empty, q_full};
        default:   rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit RAM words (power of two).
REQ-002 SHALL have parameter TXQ_DEPTH, default 4, transmit byte queue depth (power of two, >=2).
REQ-003 SHALL have ports:
- clk  input  1  clock; one clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- addr  input  32  byte address from the CPU ALU output.
- wdata  input  32  store data from the CPU.
- mem_write  input  1  store strobe.
- rdata  output  32  load data returned to the CPU.
- tx_data  output  8  head byte of the transmit queue.
- tx_valid  output  1  queue non-empty.
- tx_ready  input  1  downstream consumer accepts the byte.
- timer_irq  output  1  sticky timer-match flag.

Function
REQ-004 SHALL decode the address map: addr[31:16]==16'h0000 selects RAM; addr[31:4]==28'hFFFF000 selects I/O; all other addresses are unmapped.
REQ-005 SHALL ignore addr[1:0] everywhere (word access only).
REQ-006 SHALL index RAM with addr[log2(DEPTH_WORDS)+1:2]; higher bits inside the RAM region alias.
REQ-007 SHALL drive rdata combinationally from addr in the same cycle (zero-latency read).
REQ-008 SHALL perform a RAM write on the clock edge when mem_write=1 and RAM is selected; a same-cycle read returns the old word.
REQ-009 SHALL return 0 on reads of unmapped addresses and SHALL ignore writes to them.
REQ-010 SHALL implement I/O registers (offset from 0xFFFF0000):
- 0x0 TIMER_COUNT: R/W.
- 0x4 TIMER_CMP: R/W.
- 0x8 TX_DATA: write-only; reads as 0.
- 0xC STATUS: bit0 queue full, bit1 queue empty, bit2 timer match, bit3 overflow; remaining bits 0; writing 1 to bit2 or bit3 clears that bit.
REQ-011 SHALL increment TIMER_COUNT by 1 every cycle, wrapping 0xFFFFFFFF->0; a CPU write loads wdata and suppresses that cycle's increment.
REQ-012 SHALL set the match bit on the edge after a cycle in which TIMER_COUNT==TIMER_CMP; if a set and a clear coincide, set SHALL win.
REQ-013 SHALL drive timer_irq equal to STATUS bit2.
REQ-014 SHALL push wdata[7:0] into the transmit queue on a write to TX_DATA; the push is accepted when count<TXQ_DEPTH, or when the queue is full and a pop occurs in the same cycle.
REQ-015 SHALL drop a rejected push, leave the queue unchanged, and set overflow bit3.
REQ-016 SHALL pop when tx_valid && tx_ready; a simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-017 SHALL present tx_data as the oldest byte, stable while tx_valid=1 and tx_ready=0.
REQ-018 SHALL implement the queue as circular read/write pointers that wrap modulo TXQ_DEPTH, plus an occupancy count.

Reset
REQ-019 SHALL, while rst=1 at a clock edge, clear TIMER_COUNT, TIMER_CMP, the queue pointers and count, and STATUS bits 2 and 3; rst SHALL take priority over all writes and pops.
REQ-020 SHALL, after reset, present tx_valid=0, tx_data=0, timer_irq=0, and STATUS=0x2.
REQ-021 SHALL NOT clear RAM contents on reset.
REQ-022 SHALL discard queued bytes when reset is asserted mid-transfer.

Configuration
REQ-023 SHALL compile in the timer only when macro DMEM_TIMER_EN is defined.
REQ-024 SHALL, without DMEM_TIMER_EN, read TIMER_COUNT and TIMER_CMP as 0, ignore writes to them, hold STATUS bit2=0, and tie timer_irq=0; RAM and queue behaviour SHALL be unchanged.

Verification
REQ-025 SHALL test RAM store/load: write 0x12345678 to 0x40 -> the next-cycle read of 0x40, and of 0x43, returns 0x12345678; a read of 0x00010000 returns 0.
REQ-026 SHALL test queue full (TXQ_DEPTH=4, tx_ready=0): write bytes 0x41..0x45 -> STATUS=0x9, the queue holds 0x41..0x44, and tx_data=0x41.
REQ-027 SHALL test push on full with simultaneous pop: 4 bytes queued, then push 0x55 while tx_ready=1 -> accepted with no overflow; the drain order is 0x42, 0x43, 0x44, 0x55.
REQ-028 SHALL test the timer (DMEM_TIMER_EN): write CMP=10 and COUNT=0 -> timer_irq rises 11 cycles after the COUNT write; writing 0x4 to STATUS clears it.
REQ-029 SHALL test timer wrap: write COUNT=0xFFFFFFFF -> it reads 0x00000000 one cycle later.
REQ-030 SHALL test mid-operation reset: 3 bytes queued, assert rst -> tx_valid=0, STATUS=0x2, and a RAM word written before reset is still readable.
